reg_file_bank: RTL
==================

REG_FILE_BANK -- requirements
Module: reg_file_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width of every register and data port.
REQ-002 SHALL have parameter NREGS, default 4: register count; power of two, >= 2.
REQ-003 SHALL have parameter R0_ZERO, default 0: when 1, register 0 reads 0 and ignores writes and increments.
REQ-004 SHALL derive local AW = clog2(NREGS) as the address width.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 wr_en  input  1  write strobe.
REQ-008 wr_addr  input  AW  write address.
REQ-009 in_from_bus  input  WIDTH  write data.
REQ-010 inc_en  input  1  increment strobe.
REQ-011 inc_addr  input  AW  increment address.
REQ-012 lock_en  input  1  reserve strobe; sets the register's busy bit.
REQ-013 lock_addr  input  AW  reserve address.
REQ-014 rd_en  input  1  bus read enable.
REQ-015 rd_addr  input  AW  bus read address.
REQ-016 out_to_bus  output  WIDTH  tri-state bus read port.
REQ-017 rd_stall  output  1  bus read refused because the target register is busy.
REQ-018 rdb_addr  input  AW  debug read address.
REQ-019 rdb_data  output  WIDTH  debug read data; always driven.
REQ-020 busy  output  NREGS  per-register busy (scoreboard) bits.

Function
REQ-021 On a clock edge with wr_en=1, regs[wr_addr] SHALL load in_from_bus.
REQ-022 On a clock edge with inc_en=1 and no write to the same address that cycle, regs[inc_addr] SHALL load regs[inc_addr]+1, mod 2^WIDTH; all-ones wraps to 0.
REQ-023 When wr_en and inc_en target the same address in one cycle, the write SHALL win and the increment SHALL be dropped.
REQ-024 When wr_en and inc_en target different addresses in one cycle, both SHALL take effect.
REQ-025 On a clock edge with lock_en=1, busy[lock_addr] SHALL be set to 1.
REQ-026 A write to an address (wr_en=1) SHALL clear that address's busy bit; an increment SHALL NOT change busy bits.
REQ-027 When lock and write target the same address in one cycle, the data SHALL be written and busy SHALL end at 1 (lock wins).
REQ-028 Locking an address that is already busy SHALL leave busy at 1; no error is raised.
REQ-029 rd_stall SHALL be rd_en & busy[rd_addr], combinational.
REQ-030 out_to_bus SHALL equal regs[rd_addr] when rd_en=1 and rd_stall=0; otherwise it SHALL be all-Z.
REQ-031 rdb_data SHALL equal regs[rdb_addr] combinationally, regardless of busy state.
REQ-032 Reads SHALL return pre-edge contents; a read and a write to the same address in one cycle SHALL return the old value, with no bypass.
REQ-033 With R0_ZERO=1:
- writes, increments and locks to address 0 SHALL be ignored;
- busy[0] SHALL stay 0;
- reads of address 0 SHALL return 0.
REQ-034 Out-of-range addresses SHALL be impossible by construction, since NREGS is a power of two.

Reset
REQ-035 While reset=1, all registers SHALL be 0 and all busy bits SHALL be 0, immediately and independent of clk.
REQ-036 Reset SHALL override any same-cycle write, increment or lock.
REQ-037 During reset, rd_stall SHALL be 0; out_to_bus SHALL be Z if rd_en=0, else 0.
REQ-038 After reset deasserts, the first rising edge SHALL process strobes normally.

Verification
REQ-039 Write/read: write 16'hA5A5 to reg 2, then rd_en=1 with rd_addr=2 -> out_to_bus=16'hA5A5; with rd_en=0 -> out_to_bus=16'hZZZZ.
REQ-040 Increment wrap: write 16'hFFFF to reg 1, then inc_en on reg 1 -> rdb_data=16'h0000; in the same cycle, wr_en and inc_en on reg 3 with data 16'h0010 -> reg 3 = 16'h0010.
REQ-041 Scoreboard: lock reg 1, then rd_en with rd_addr=1 -> rd_stall=1 and out_to_bus Z, while rdb_data still returns the contents; write 16'h0042 to reg 1 -> busy[1]=0 and the bus read returns 16'h0042.
REQ-042 Lock/write collision: in one cycle, lock_en and wr_en both on reg 2 with data 16'h1234 -> busy[2]=1 and rdb_data=16'h1234.
REQ-043 Reset mid-operation: regs hold nonzero values and busy=4'b1010; pulse reset between edges -> all regs 0, busy=0 before the next edge, and a write asserted in that cycle is discarded.
REQ-044 R0_ZERO=1 build: write 16'h5555 to reg 0, increment reg 0 and lock reg 0 -> bus read of reg 0 returns 0 and busy[0]=0.

Source files
------------

// File: rtl/reg_file_bank.sv
// Small register file with per-register increment and a busy scoreboard.
// Bus reads of a busy register are refused; the debug port always sees the data.

module reg_file_cell #(
  parameter int WIDTH = 16,
  parameter bit ZERO  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             inc,
  input  logic             lock,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] data,
  output logic             busy
);
  logic [WIDTH-1:0] data_d, data_q;
  logic             busy_d, busy_q;

  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    // a write beats an increment; a lock beats the write's busy clear
    if (wr) begin
      data_d = wdata;
      busy_d = 1'b0;
    end else if (inc) begin
      data_d = data_q + WIDTH'(1);
    end
    if (lock) busy_d = 1'b1;
    if (ZERO) begin
      data_d = '0;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign data = data_q;
  assign busy = busy_q;
endmodule

module reg_file_bank #(
  parameter int WIDTH   = 16,
  parameter int NREGS   = 4,
  parameter int R0_ZERO = 0,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] in_from_bus,
  input  logic             inc_en,
  input  logic [AW-1:0]    inc_addr,
  input  logic             lock_en,
  input  logic [AW-1:0]    lock_addr,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] out_to_bus,
  output logic             rd_stall,
  input  logic [AW-1:0]    rdb_addr,
  output logic [WIDTH-1:0] rdb_data,
  output logic [NREGS-1:0] busy
);
  logic [NREGS-1:0][WIDTH-1:0] regs;
  logic [NREGS-1:0]            busy_w;

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    reg_file_cell #(
      .WIDTH (WIDTH),
      .ZERO  ((R0_ZERO != 0) && (i == 0))
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .wr    (wr_en   && (wr_addr   == AW'(i))),
      .inc   (inc_en  && (inc_addr  == AW'(i))),
      .lock  (lock_en && (lock_addr == AW'(i))),
      .wdata (in_from_bus),
      .data  (regs[i]),
      .busy  (busy_w[i])
    );
  end

  assign busy       = busy_w;
  assign rd_stall   = rd_en & busy_w[rd_addr];
  assign out_to_bus = (rd_en && !rd_stall) ? regs[rd_addr] : {WIDTH{1'bz}};
  assign rdb_data   = regs[rdb_addr];
endmodule
